// File: rtl/coo_aggregate_argmax.sv
// Final GCN stage: walks a COO edge list one edge per cycle, accumulating neighbour rows of the
// FM*WM product per node, then scans each node's aggregate to produce its argmax class index.
module coo_aggregate_argmax #(
  parameter int FEATURE_ROWS      = 6,
  parameter int WEIGHT_COLS       = 3,
  parameter int DOT_PROD_WIDTH    = 16,
  parameter int NUM_OF_NODES      = 6,
  parameter int COO_NUM_OF_COLS   = 6,
  parameter int COO_BW            = $clog2(COO_NUM_OF_COLS),
  parameter int MAX_ADDRESS_WIDTH = 2
) (
  input  logic                                                       clk,
  input  logic                                                       reset,
  input  logic                                                       start,
  input  logic                                                       fmwm_valid,
  input  logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] fm_wm_in,
  output logic [COO_BW-1:0]                                          coo_address,
  input  logic [2*COO_BW-1:0]                                        coo_in,
  output logic                                                       coo_err,
  output logic                                                       done,
  output logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0]             max_addi_answer,
  output logic [1:0]                                                 state_dbg
);

  // Handshake: start is a level sampled only in IDLE together with fmwm_valid; done is held high
  // in DONE until start is observed low, so a level-held start never triggers a second run.

  localparam int NODE_BW = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
  localparam logic [COO_BW:0] NODE_LIMIT = (COO_BW+1)'(NUM_OF_NODES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EDGE = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] row_t;

  state_t state_q, state_d;

  row_t [FEATURE_ROWS-1:0]  acc;
  logic [NODE_BW-1:0]       node_ptr;

  logic [COO_BW-1:0]            src, dst;
  logic                         edge_ok;
  logic                         last_edge, last_node;
  row_t                         src_row, dst_row, scan_row;
  logic [MAX_ADDRESS_WIDTH-1:0] best_idx;
  logic [DOT_PROD_WIDTH-1:0]    best_val;

  assign src       = coo_in[2*COO_BW-1:COO_BW];
  assign dst       = coo_in[COO_BW-1:0];
  assign edge_ok   = ({1'b0, src} < NODE_LIMIT) && ({1'b0, dst} < NODE_LIMIT);
  assign last_edge = (coo_address == COO_BW'(COO_NUM_OF_COLS - 1));
  assign last_node = (node_ptr == NODE_BW'(NUM_OF_NODES - 1));
  assign state_dbg = state_q;

  always_comb begin
    src_row  = '0;
    dst_row  = '0;
    scan_row = '0;
    for (int r = 0; r < FEATURE_ROWS; r++) begin
      if (COO_BW'(r) == src) src_row = fm_wm_in[r];
      if (COO_BW'(r) == dst) dst_row = fm_wm_in[r];
      if (NODE_BW'(r) == node_ptr) scan_row = acc[r];
    end
  end

  // Strict greater-than keeps the lowest column index on ties.
  always_comb begin
    best_idx = '0;
    best_val = scan_row[0];
    for (int c = 1; c < WEIGHT_COLS; c++) begin
      if (scan_row[c] > best_val) begin
        best_val = scan_row[c];
        best_idx = MAX_ADDRESS_WIDTH'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && fmwm_valid) state_d = ST_EDGE;
      ST_EDGE: if (last_edge)           state_d = ST_SCAN;
      ST_SCAN: if (last_node)           state_d = ST_DONE;
      ST_DONE: if (!start && done)      state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc             <= '0;
      node_ptr        <= '0;
      coo_address     <= '0;
      coo_err         <= 1'b0;
      done            <= 1'b0;
      max_addi_answer <= '0;
    end else begin
      // done rises one cycle after entering DONE and drops on the same edge that leaves it.
      done <= (state_q == ST_DONE) && (state_d == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (state_d == ST_EDGE) begin
            acc         <= '0;
            coo_err     <= 1'b0;
            coo_address <= '0;
            node_ptr    <= '0;
          end
        end
        ST_EDGE: begin
          if (edge_ok) begin
            // A self-loop matches the dst branch only, so it is added once.
            for (int n = 0; n < FEATURE_ROWS; n++) begin
              for (int c = 0; c < WEIGHT_COLS; c++) begin
                if (COO_BW'(n) == dst)      acc[n][c] <= acc[n][c] + src_row[c];
                else if (COO_BW'(n) == src) acc[n][c] <= acc[n][c] + dst_row[c];
              end
            end
          end else begin
            coo_err <= 1'b1;
          end
          if (last_edge) node_ptr    <= '0;
          else           coo_address <= coo_address + 1'b1;
        end
        ST_SCAN: begin
          for (int n = 0; n < FEATURE_ROWS; n++) begin
            if (NODE_BW'(n) == node_ptr) max_addi_answer[n] <= best_idx;
          end
          if (!last_node) node_ptr <= node_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coo_aggregate_argmax.sv
// Bench for coo_aggregate_argmax: directed scenarios plus randomized runs checked against an
// edge-list aggregation model, with results queued and compared whenever done is high.
module tb_coo_aggregate_argmax;

  localparam int ROWS = 6;
  localparam int COLS = 3;
  localparam int DW   = 16;
  localparam int BW   = 3;
  localparam int AW   = 2;
  localparam int W    = 1 + ROWS*AW;

  logic                                clk = 1'b0;
  logic                                reset;
  logic                                start;
  logic                                fmwm_valid;
  logic [ROWS-1:0][COLS-1:0][DW-1:0]   fm_wm_in;
  logic [BW-1:0]                       coo_address;
  logic [2*BW-1:0]                     coo_in;
  logic                                coo_err;
  logic                                done;
  logic [ROWS-1:0][AW-1:0]             max_addi_answer;
  logic [1:0]                          state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  // Model data: the matrix, the COO memory and the expected results.
  logic [DW-1:0]         m_fm[ROWS][COLS];
  logic [BW-1:0]         m_src[8];
  logic [BW-1:0]         m_dst[8];
  logic [DW-1:0]         m_acc[ROWS][COLS];
  logic [ROWS-1:0][AW-1:0] m_ans;
  logic                  m_err;

  logic [W-1:0] exp_q[$];

  coo_aggregate_argmax dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .fmwm_valid      (fmwm_valid),
    .fm_wm_in        (fm_wm_in),
    .coo_address     (coo_address),
    .coo_in          (coo_in),
    .coo_err         (coo_err),
    .done            (done),
    .max_addi_answer (max_addi_answer),
    .state_dbg       (state_dbg)
  );

  always #5 clk = ~clk;

  // COO memory answers combinationally in the same cycle.
  always_comb coo_in = {m_src[coo_address], m_dst[coo_address]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_model();
    int s, d, best;
    m_err = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_acc[r][c] = '0;
    for (int k = 0; k < 6; k++) begin
      s = int'(m_src[k]);
      d = int'(m_dst[k]);
      if (s >= ROWS || d >= ROWS) m_err = 1'b1;
      else if (s == d) begin
        for (int c = 0; c < COLS; c++) m_acc[s][c] = m_acc[s][c] + m_fm[s][c];
      end else begin
        for (int c = 0; c < COLS; c++) begin
          m_acc[d][c] = m_acc[d][c] + m_fm[s][c];
          m_acc[s][c] = m_acc[s][c] + m_fm[d][c];
        end
      end
    end
    for (int n = 0; n < ROWS; n++) begin
      best = 0;
      for (int c = 1; c < COLS; c++) if (m_acc[n][c] > m_acc[n][best]) best = c;
      m_ans[n] = AW'(best);
    end
  endtask

  task automatic clear_data();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_fm[r][c] = '0;
    for (int k = 0; k < 8; k++) begin
      m_src[k] = 3'd0;
      m_dst[k] = 3'd1;
    end
  endtask

  task automatic set_row(input int r, input int a, input int b, input int c);
    m_fm[r][0] = DW'(a);
    m_fm[r][1] = DW'(b);
    m_fm[r][2] = DW'(c);
  endtask

  task automatic set_all_edges(input int s, input int d);
    for (int k = 0; k < 6; k++) begin
      m_src[k] = BW'(s);
      m_dst[k] = BW'(d);
    end
  endtask

  task automatic launch();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) fm_wm_in[r][c] = m_fm[r][c];
    run_model();
    exp_q.push_back({m_err, m_ans});
    @(negedge clk);
    start      = 1'b1;
    fmwm_valid = 1'b1;
    @(posedge clk);
  endtask

  // drop_after: cycle after launch at which start is released (0 = keep it high until done).
  task automatic run_case(input int drop_after, input int hold_cycles);
    int cycles;
    launch();
    cycles = 0;
    while (!done && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == drop_after) start = 1'b0;
    end
    check("latency", 32'(cycles), 32'd13);
    if (start) begin
      for (int i = 0; i < hold_cycles; i++) begin
        @(posedge clk);
        #1;
        check("done_held_with_start", 32'(done), 32'd1);
      end
      start = 1'b0;
    end
    @(posedge clk);
    #1;
    check("done_falls", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check("no_restart", 32'(done), 32'd0);
  endtask

  // Compare process: results must match the queued expectation on every cycle done is high.
  logic [W-1:0] cur_exp;
  logic         done_prev;
  always @(negedge clk) begin
    if (!reset) begin
      done_prev = 1'b0;
    end else begin
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected no pending run at %0t", $time);
          cur_exp = '0;
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      if (done) check("result", 32'({coo_err, max_addi_answer}), 32'(cur_exp));
      done_prev = done;
    end
  end

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    fmwm_valid = 1'b0;
    fm_wm_in   = '0;
    clear_data();
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_ans", 32'(max_addi_answer), 32'd0);
    check("rst_err", 32'(coo_err), 32'd0);
    check("rst_addr", 32'(coo_address), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // All-zero matrix.
    clear_data();
    run_model();
    check("pin_s1_ans", 32'(m_ans), 32'h000);
    run_case(0, 0);

    // Two populated rows, edge (0,1) six times.
    clear_data();
    set_row(0, 1, 9, 2);
    set_row(1, 5, 0, 0);
    run_model();
    check("pin_s2_ans", 32'(m_ans), 32'h004);
    check("pin_s2_acc1", {8'd0, m_acc[1][0][7:0], m_acc[1][1][7:0], m_acc[1][2][7:0]}, 32'h00_06_36_0C);
    check("pin_s2_acc0", 32'(m_acc[0][0]), 32'd30);
    run_case(0, 2);

    // Tie resolves to the lowest column.
    clear_data();
    set_row(3, 4, 4, 1);
    set_all_edges(2, 3);
    run_model();
    check("pin_s3_ans", 32'(m_ans), 32'h000);
    run_case(0, 0);

    // Out-of-range edge at k=2 is skipped and flagged.
    clear_data();
    set_row(0, 0, 0, 3);
    set_row(1, 0, 2, 0);
    m_src[2] = 3'd7;
    m_dst[2] = 3'd1;
    run_model();
    check("pin_s4_ans", 32'(m_ans), 32'h009);
    check("pin_s4_err", 32'(m_err), 32'd1);
    run_case(0, 1);

    // Self-loop adds once per edge.
    clear_data();
    set_row(2, 1, 2, 3);
    set_all_edges(2, 2);
    run_model();
    check("pin_s5_ans", 32'(m_ans), 32'h020);
    check("pin_s5_acc2", {8'd0, m_acc[2][0][7:0], m_acc[2][1][7:0], m_acc[2][2][7:0]}, 32'h00_06_0C_12);
    run_case(0, 0);

    // Async reset in the middle of EDGE, then a clean rerun held past done.
    clear_data();
    set_row(0, 1, 9, 2);
    set_row(1, 5, 0, 0);
    launch();
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_done", 32'(done), 32'd0);
    check("abort_ans", 32'(max_addi_answer), 32'd0);
    check("abort_err", 32'(coo_err), 32'd0);
    check("abort_addr", 32'(coo_address), 32'd0);
    exp_q.delete();
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_case(0, 8);

    // Randomized runs, including wrapping sums and occasional out-of-range indices.
    for (int i = 0; i < 24; i++) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          m_fm[r][c] = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 3))
                                                   : DW'($urandom_range(0, 65535));
      for (int k = 0; k < 6; k++) begin
        m_src[k] = ($urandom_range(0, 9) == 0) ? BW'($urandom_range(6, 7)) : BW'($urandom_range(0, 5));
        m_dst[k] = ($urandom_range(0, 9) == 0) ? BW'($urandom_range(6, 7)) : BW'($urandom_range(0, 5));
      end
      run_case(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 12)), int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
